// File: rtl/enigma_stream_ctrl_if.sv
// Host and core-facing signal bundle for enigma_stream_ctrl.
// slave is the controller's view; master is the host/core side.
interface enigma_stream_ctrl_if;
  logic       cfg_set;
  logic       cfg_dec;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       eng_set;
  logic       eng_en;
  logic       eng_valid;
  logic [7:0] eng_din;
  logic       eng_dec;
  logic       eng_done;
  logic [7:0] eng_dout;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
  logic       err;

  modport slave (
    input  cfg_set, cfg_dec, in_valid, in_data, eng_done, eng_dout, out_ready,
    output in_ready, eng_set, eng_en, eng_valid, eng_din, eng_dec,
           out_valid, out_data, busy, err
  );

  modport master (
    output cfg_set, cfg_dec, in_valid, in_data, eng_done, eng_dout, out_ready,
    input  in_ready, eng_set, eng_en, eng_valid, eng_din, eng_dec,
           out_valid, out_data, busy, err
  );
endinterface

// File: rtl/enigma_stream_ctrl.sv
// Stream front-end for the enigma core: buffers host bytes, issues alphabet
// symbols to the core one at a time, bypasses other bytes, holds each result for the host.
module enigma_stream_ctrl #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned NSYM    = 26,
  parameter int unsigned TIMEOUT = 64
) (
  input logic                 clk,
  input logic                 reset_n,
  enigma_stream_ctrl_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  localparam logic [8:0]    NSYM_L = 9'(NSYM);
  localparam logic [TW-1:0] TMAX   = TW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]    r_state;
  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [TW-1:0] r_timer;
  logic          r_en;
  logic          r_eng_set;
  logic          r_eng_valid;
  logic [7:0]    r_eng_din;
  logic          r_eng_dec;
  logic          r_out_valid;
  logic [7:0]    r_out_data;
  logic          r_busy;
  logic          r_err;

  logic          w_empty;
  logic          w_full;
  logic          w_in_ready;
  logic          w_push;
  logic [7:0]    w_head;

  logic [1:0]    w_state_nxt;
  logic          w_pop;
  logic          w_flush;
  logic [TW-1:0] w_timer_nxt;
  logic          w_eng_valid_nxt;
  logic [7:0]    w_eng_din_nxt;
  logic          w_out_valid_nxt;
  logic [7:0]    w_out_data_nxt;
  logic          w_err_nxt;
  logic [PW-1:0] w_wr_ptr_nxt;
  logic [PW-1:0] w_rd_ptr_nxt;
  logic          w_busy_nxt;

  // FIFO status: the extra pointer bit separates full from empty
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_in_ready = r_en & ~w_full & ~bus.cfg_set;
  assign w_push     = bus.in_valid & w_in_ready;
  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= bus.in_data;
    end
  end

  // Next-state and registered-output logic; cfg_set overrides every state
  always_comb begin
    w_state_nxt     = r_state;
    w_pop           = 1'b0;
    w_flush         = 1'b0;
    w_timer_nxt     = r_timer;
    w_eng_valid_nxt = 1'b0;
    w_eng_din_nxt   = r_eng_din;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_err_nxt       = r_err;

    if (bus.cfg_set) begin
      w_flush         = 1'b1;
      w_state_nxt     = S_IDLE;
      w_out_valid_nxt = 1'b0;
      w_err_nxt       = 1'b0;
      w_timer_nxt     = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty && !r_out_valid) begin
            w_pop = 1'b1;
            if ({1'b0, w_head} < NSYM_L) begin
              w_eng_valid_nxt = 1'b1;
              w_eng_din_nxt   = w_head;
              w_timer_nxt     = '0;
              w_state_nxt     = S_ISSUE;
            end else begin
              w_out_data_nxt  = w_head;
              w_out_valid_nxt = 1'b1;
              w_state_nxt     = S_HOLD;
            end
          end
        end
        S_ISSUE: begin
          w_timer_nxt = r_timer + TW'(1);
          w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (bus.eng_done) begin
            w_out_data_nxt  = bus.eng_dout;
            w_out_valid_nxt = 1'b1;
            w_state_nxt     = S_HOLD;
          end else if (r_timer == TMAX) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end
        S_HOLD: begin
          if (r_out_valid && bus.out_ready) begin
            w_out_valid_nxt = 1'b0;
            w_state_nxt     = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    w_wr_ptr_nxt = w_flush ? '0 : r_wr_ptr + PW'(w_push);
    w_rd_ptr_nxt = w_flush ? '0 : r_rd_ptr + PW'(w_pop);
    w_busy_nxt   = (w_state_nxt != S_IDLE) || (w_wr_ptr_nxt != w_rd_ptr_nxt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_timer     <= '0;
      r_en        <= 1'b0;
      r_eng_set   <= 1'b0;
      r_eng_valid <= 1'b0;
      r_eng_din   <= '0;
      r_eng_dec   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_timer     <= w_timer_nxt;
      r_en        <= 1'b1;
      r_eng_set   <= bus.cfg_set;
      r_eng_valid <= w_eng_valid_nxt;
      r_eng_din   <= w_eng_din_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_busy      <= w_busy_nxt;
      r_err       <= w_err_nxt;
      // Decrypt select only changes between symbols
      if (r_state == S_IDLE) begin
        r_eng_dec <= bus.cfg_dec;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.eng_set   = r_eng_set;
  assign bus.eng_en    = r_en;
  assign bus.eng_valid = r_eng_valid;
  assign bus.eng_din   = r_eng_din;
  assign bus.eng_dec   = r_eng_dec;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.busy      = r_busy;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_enigma_stream_ctrl.sv
// Scoreboard bench for enigma_stream_ctrl: a behavioural core model answers
// eng_valid, expected host outputs are queued at push time and checked by a monitor.
module tb_enigma_stream_ctrl;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned NSYM    = 26;
  localparam int unsigned TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  enigma_stream_ctrl_if sif();

  enigma_stream_ctrl #(.DEPTH(DEPTH), .NSYM(NSYM), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (sif)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int         ref_k = 0;
  int         k_base = 0;
  int         core_k = 0;
  logic       tb_dec = 1'b0;
  bit         mute = 1'b0;
  int         lat_lo = 1;
  int         lat_hi = 1;
  int         stray_cnt = 0;
  int         rdy_mode = 1;
  int         n_valid = 0;
  int         last_v_cyc = 0;
  logic [7:0] cap_din = 8'h00;
  bit         core_pend = 1'b0;
  int         ov_rises = 0;
  int         ov_rise_cyc = 0;
  logic [7:0] ov_rise_data = 8'h00;
  int         hs_cnt = 0;
  int         push_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Rotor-like substitution: shift grows by one per symbol, reversed when decrypting
  function automatic logic [7:0] fmap(input logic [7:0] d, input int k, input logic dec);
    int s;
    int r;
    s = (4 + k) % 26;
    if (dec) r = (int'(d) + 26 - s) % 26;
    else     r = (int'(d) + s) % 26;
    return 8'(r);
  endfunction

  task automatic enq_exp(input logic [7:0] b);
    if (int'(b) < int'(NSYM)) begin
      exp_q.push_back(fmap(b, ref_k, tb_dec));
      ref_k++;
    end else begin
      exp_q.push_back(b);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] b, input bit enq, output bit ok);
    int guard;
    ok = 1'b0;
    guard = 0;
    sif.in_valid = 1'b1;
    sif.in_data  = b;
    while (!sif.in_ready && guard < 300) begin
      tick();
      guard++;
    end
    chk("push_accept", 32'(sif.in_ready), 32'd1);
    if (sif.in_ready) begin
      ok = 1'b1;
      push_cyc = cyc;
      if (enq) enq_exp(b);
    end
    tick();
    sif.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || sif.busy || core_pend) && g < 4000) begin
      tick();
      g++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_rise(input int start, input string name);
    int g;
    g = 0;
    while (ov_rises == start && g < 300) begin
      tick();
      g++;
    end
    chk(name, 32'(ov_rises != start), 32'd1);
  endtask

  // Host sink: out_ready pattern selected by rdy_mode
  initial begin
    sif.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       sif.out_ready = 1'b0;
        1:       sif.out_ready = 1'b1;
        2:       sif.out_ready = ~sif.out_ready;
        default: sif.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Core model: answers each eng_valid after a random latency unless muted
  initial begin
    int         cnt;
    int         stray_seen;
    logic [7:0] resp;
    logic       prev_ev;
    cnt = 0;
    stray_seen = 0;
    resp = 8'h00;
    prev_ev = 1'b0;
    sif.eng_done = 1'b0;
    sif.eng_dout = 8'h00;
    forever begin
      @(negedge clk);
      sif.eng_done = 1'b0;
      if (core_pend) begin
        if (cnt <= 1) begin
          chk("eng_din_stable", 32'(sif.eng_din), 32'(cap_din));
          sif.eng_done = 1'b1;
          sif.eng_dout = resp;
          core_pend = 1'b0;
          core_k++;
        end else begin
          cnt--;
        end
      end
      if (stray_seen != stray_cnt) begin
        stray_seen++;
        sif.eng_done = 1'b1;
        sif.eng_dout = 8'h55;
      end
      if (sif.eng_valid) begin
        chk("eng_valid_pulse", 32'(prev_ev), 32'd0);
        chk("core_overlap", 32'(core_pend), 32'd0);
        n_valid++;
        last_v_cyc = cyc;
        cap_din = sif.eng_din;
        if (!mute) begin
          core_pend = 1'b1;
          cnt = int'($urandom_range(lat_hi, lat_lo));
          resp = fmap(sif.eng_din, core_k - k_base, sif.eng_dec);
        end
      end
      prev_ev = sif.eng_valid;
    end
  end

  // Monitor: scoreboard pop on each output handshake, plus hold stability
  initial begin
    logic       prev_ov;
    logic       prev_rdy;
    logic       prev_cfg;
    logic [7:0] prev_data;
    prev_ov = 1'b0;
    prev_rdy = 1'b0;
    prev_cfg = 1'b0;
    prev_data = 8'h00;
    forever begin
      @(negedge clk);
      #3;
      if (sif.cfg_set) exp_q.delete();
      if (prev_ov && !prev_rdy && !prev_cfg && reset_n) begin
        chk("hold_valid", 32'(sif.out_valid), 32'd1);
        chk("hold_data", 32'(sif.out_data), 32'(prev_data));
      end
      if (sif.out_valid && !prev_ov) begin
        ov_rises++;
        ov_rise_cyc = cyc;
        ov_rise_data = sif.out_data;
      end
      if (sif.out_valid && sif.out_ready && !sif.cfg_set) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got 0x%0h, expected no output (cycle %0d)", sif.out_data, cyc);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("out_data", 32'(sif.out_data), 32'(e));
        end
      end
      prev_ov = sif.out_valid;
      prev_rdy = sif.out_ready;
      prev_cfg = sif.cfg_set;
      prev_data = sif.out_data;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit         ok;
    int         start;
    int         vstart;
    int         acc;
    int         pc;
    int         g;
    int         errc;
    logic       last_rdy;
    logic [7:0] b;

    sif.cfg_set = 1'b0;
    sif.cfg_dec = 1'b0;
    sif.in_valid = 1'b0;
    sif.in_data = 8'h00;
    rdy_mode = 1;
    reset_n = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_in_ready", 32'(sif.in_ready), 32'd0);
    chk("rst_eng_en", 32'(sif.eng_en), 32'd0);
    chk("rst_eng_valid", 32'(sif.eng_valid), 32'd0);
    chk("rst_out_valid", 32'(sif.out_valid), 32'd0);
    chk("rst_busy", 32'(sif.busy), 32'd0);
    chk("rst_err", 32'(sif.err), 32'd0);
    chk("rst_eng_set", 32'(sif.eng_set), 32'd0);
    chk("rst_out_data", 32'(sif.out_data), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(sif.in_ready), 32'd1);
    chk("post_rst_eng_en", 32'(sif.eng_en), 32'd1);

    // 1: single symbol through the core, latency 7
    lat_lo = 7;
    lat_hi = 7;
    start = ov_rises;
    vstart = n_valid;
    push(8'h00, 1'b1, ok);
    wait_rise(start, "t1_out_seen");
    chk("t1_valid_count", 32'(n_valid - vstart), 32'd1);
    chk("t1_din", 32'(cap_din), 32'h00);
    chk("t1_latency", 32'(ov_rise_cyc - last_v_cyc), 32'd8);
    chk("t1_data", 32'(ov_rise_data), 32'h04);
    wait_drain("t1_drain");

    // 2: non-alphabet byte bypasses the core
    start = ov_rises;
    vstart = n_valid;
    push(8'h20, 1'b1, ok);
    pc = push_cyc;
    wait_rise(start, "t2_out_seen");
    chk("t2_latency", 32'(ov_rise_cyc - pc), 32'd2);
    chk("t2_data", 32'(ov_rise_data), 32'h20);
    chk("t2_no_core", 32'(n_valid - vstart), 32'd0);
    wait_drain("t2_drain");

    // 3: FSM parked in HOLD, then fill the FIFO: 16 accepted, 17th refused
    rdy_mode = 0;
    lat_lo = 1;
    lat_hi = 4;
    push(8'h30, 1'b1, ok);
    g = 0;
    while (!sif.out_valid && g < 50) begin
      tick();
      g++;
    end
    chk("t3_hold", 32'(sif.out_valid), 32'd1);
    acc = 0;
    last_rdy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom_range(0, 40));
      sif.in_valid = 1'b1;
      sif.in_data = b;
      last_rdy = sif.in_ready;
      if (sif.in_ready) begin
        acc++;
        enq_exp(b);
      end
      tick();
    end
    sif.in_valid = 1'b0;
    chk("t3_accepted", 32'(acc), 32'd16);
    chk("t3_byte17_refused", 32'(last_rdy), 32'd0);
    rdy_mode = 1;
    wait_drain("t3_drain");

    // 4: core never answers -> timeout, recovery, stray done ignored
    mute = 1'b1;
    start = ov_rises;
    push(8'd5, 1'b0, ok);
    g = 0;
    while (!sif.err && g < 300) begin
      tick();
      g++;
    end
    errc = cyc;
    chk("t4_err", 32'(sif.err), 32'd1);
    chk("t4_timeout_cycles", 32'(errc - last_v_cyc), 32'(TIMEOUT));
    chk("t4_no_output", 32'(ov_rises - start), 32'd0);
    mute = 1'b0;
    lat_lo = 3;
    lat_hi = 3;
    push(8'd1, 1'b1, ok);
    wait_drain("t4_next_symbol");
    chk("t4_next_out", 32'(ov_rises - start), 32'd1);
    start = ov_rises;
    stray_cnt++;
    repeat (6) tick();
    chk("t4_stray_ignored", 32'(ov_rises - start), 32'd0);
    chk("t4_err_sticky", 32'(sif.err), 32'd1);
    chk("t4_idle", 32'(sif.busy), 32'd0);

    // 5: cfg_set with a symbol in WAIT and five bytes queued
    mute = 1'b1;
    vstart = n_valid;
    for (int i = 0; i < 6; i++) push(8'(i + 2), 1'b0, ok);
    tick();
    chk("t5_busy_before", 32'(sif.busy), 32'd1);
    chk("t5_one_issued", 32'(n_valid - vstart), 32'd1);
    sif.cfg_set = 1'b1;
    #1;
    chk("t5_in_ready_low", 32'(sif.in_ready), 32'd0);
    chk("t5_eng_set_lag", 32'(sif.eng_set), 32'd0);
    tick();
    chk("t5_busy", 32'(sif.busy), 32'd0);
    chk("t5_out_valid", 32'(sif.out_valid), 32'd0);
    chk("t5_err_cleared", 32'(sif.err), 32'd0);
    chk("t5_eng_set", 32'(sif.eng_set), 32'd1);
    chk("t5_eng_valid", 32'(sif.eng_valid), 32'd0);
    sif.cfg_set = 1'b0;
    tick();
    chk("t5_eng_set_fall", 32'(sif.eng_set), 32'd0);
    chk("t5_in_ready_back", 32'(sif.in_ready), 32'd1);
    mute = 1'b0;
    start = ov_rises;
    stray_cnt++;
    repeat (80) tick();
    chk("t5_flushed_no_out", 32'(ov_rises - start), 32'd0);
    chk("t5_still_idle", 32'(sif.busy), 32'd0);
    k_base = core_k;
    ref_k = 0;

    // 6: out_ready toggling over "h i"
    rdy_mode = 2;
    lat_lo = 1;
    lat_hi = 3;
    start = hs_cnt;
    push(8'h07, 1'b1, ok);
    push(8'h20, 1'b1, ok);
    push(8'h08, 1'b1, ok);
    wait_drain("t6_drain");
    chk("t6_handshakes", 32'(hs_cnt - start), 32'd3);

    // Random traffic, alternating encrypt/decrypt per block
    for (int blk = 0; blk < 4; blk++) begin
      tb_dec = 1'(blk % 2);
      sif.cfg_dec = tb_dec;
      rdy_mode = (blk % 2 == 1) ? 3 : 1;
      lat_lo = 1;
      lat_hi = 12;
      tick();
      tick();
      for (int i = 0; i < 12; i++) begin
        if ($urandom_range(0, 1) == 1) b = 8'($urandom_range(0, 25));
        else                           b = 8'($urandom_range(0, 255));
        push(b, 1'b1, ok);
        repeat ($urandom_range(0, 2)) tick();
      end
      wait_drain("rand_drain");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
